// File: rtl/prog_arbiter_pkg.sv
// Shared constants for the program-load arbiter: state encoding, parameter
// defaults and the width helper for the reset-hold counter.
package prog_arbiter_pkg;

  localparam int AW_DEF       = 6;
  localparam int DW_DEF       = 8;
  localparam int RST_HOLD_DEF = 2;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Counter width able to hold the value 'hold'; never narrower than one bit.
  function automatic int hold_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/prog_arbiter_hold_timer.sv
// Down-counter that keeps the processor in reset for HOLD cycles after a
// system reset or after a program load.
module hold_timer
  import prog_arbiter_pkg::*;
#(
  parameter int HOLD = RST_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic active,
  output logic last
);

  localparam int CW = hold_width(HOLD);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= CW'(HOLD);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign active = (count != '0);
  assign last   = (count == CW'(1));

endmodule

// File: rtl/prog_arbiter.sv
// Arbitrates an external program RAM between CPU instruction fetches and a
// host program loader, holding the CPU in reset while it is being reloaded.
module prog_arbiter
  import prog_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_end,
  output logic          ld_ready,
  output logic          ld_done,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_rstn,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  logic [1:0]    state;
  logic [AW-1:0] wr_cnt;
  logic          load_exit;
  logic          hold_active;
  logic          hold_last;

  // Leave LOAD on host terminate, or right after writing the top address so
  // the counter can never wrap back onto address 0 within one load.
  assign load_exit = (state == ST_LOAD) &&
                     (ld_end || (ld_valid && (wr_cnt == '1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      wr_cnt  <= '0;
      cpu_ack <= 1'b0;
    end else begin
      cpu_ack <= (state == ST_RUN) && cpu_req;
      case (state)
        ST_RUN: begin
          if (ld_start) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state  <= ST_LOAD;
          wr_cnt <= '0;
        end
        ST_LOAD: begin
          if (ld_valid) wr_cnt <= wr_cnt + AW'(1);
          if (load_exit) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (hold_last) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  hold_timer #(
    .HOLD(RST_HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load_exit),
    .active(hold_active),
    .last  (hold_last)
  );

  // Reads have one cycle of RAM latency, so fetch data is a direct pass-through.
  assign cpu_data  = mem_rdata;
  assign mem_addr  = (state == ST_LOAD) ? wr_cnt : cpu_addr;
  assign mem_wdata = ld_data;
  assign mem_we    = (state == ST_LOAD) && ld_valid;
  assign ld_ready  = (state == ST_LOAD);
  assign ld_done   = (state == ST_RELEASE) && hold_last;
  assign cpu_rstn  = (state == ST_RUN) && !hold_active;
  assign busy      = (state != ST_RUN);

endmodule
